// File: rtl/falafel_pkg.sv
// falafel_pkg: types and constants shared by the falafel allocator blocks.
//   DATA_W                 : machine word / address width
//   BLOCK_NEXT_ADDR_OFFSET : byte offset of the next_addr word inside a block header
//   EMPTY_KEY              : value of a free lock word
//   LOCK_ADDR_DEFAULT      : default byte address of the allocator lock word
//   LOCK_SET_VAL_DEFAULT   : default value written to claim the lock
//   header_t / header_req_t / header_rsp_t / req_lsu_op_e : LSU request/response types
package falafel_pkg;

  localparam int DATA_W = 64;

  localparam logic [DATA_W-1:0] BLOCK_NEXT_ADDR_OFFSET = 64'd8;
  localparam logic [DATA_W-1:0] EMPTY_KEY              = 64'h0;
  localparam logic [DATA_W-1:0] LOCK_ADDR_DEFAULT      = 64'h0;
  localparam logic [DATA_W-1:0] LOCK_SET_VAL_DEFAULT   = 64'h1;

  // Codes 5..7 are unrecognised and answered without memory traffic.
  typedef enum logic [2:0] {
    LOAD                    = 3'd0,
    EDIT_SIZE_AND_NEXT_ADDR = 3'd1,
    EDIT_NEXT_ADDR          = 3'd2,
    LOCK                    = 3'd3,
    UNLOCK                  = 3'd4
  } req_lsu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] size;
    logic [DATA_W-1:0] next_addr;
  } header_t;

  typedef struct packed {
    logic        val;
    req_lsu_op_e lsu_op;
    header_t     header;
  } header_req_t;

  typedef struct packed {
    logic    val;
    header_t header;
  } header_rsp_t;

endpackage

// File: rtl/falafel_lsu_if.sv
// falafel_lsu_if: bundle of the falafel_lsu request/response and word-memory signals.
//   req/req_rdy          : allocator request handshake (header_req_t)
//   rsp/rsp_rdy          : response handshake (header_rsp_t)
//   mem_req/we/addr/wdata: word memory request, held until mem_gnt
//   mem_gnt/rvalid/rdata : grant, read-data valid, read data
// Modports: master = requester + memory side, slave = the LSU.
interface falafel_lsu_if;
  import falafel_pkg::*;

  header_req_t       req;
  logic              req_rdy;
  header_rsp_t       rsp;
  logic              rsp_rdy;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req, rsp_rdy, mem_gnt, mem_rvalid, mem_rdata,
    input  req_rdy, rsp, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req, rsp_rdy, mem_gnt, mem_rvalid, mem_rdata,
    output req_rdy, rsp, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/falafel_lsu.sv
// falafel_lsu: load/store unit that walks allocator block headers in word memory.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   req_i / req_rdy_o   : request in (header_req_t), accepted when both high
//   rsp_o / rsp_rdy_i   : registered response out (header_rsp_t), consumed when both high
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o : memory request, held until mem_gnt_i
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i         : grant, read-data valid, read data
// Operations: LOAD reads size and next_addr; EDIT_* write them; LOCK spins on the
// lock word until free then claims it; UNLOCK frees it; other codes just echo.
// Build option: define FALAFEL_LSU_LOCK_EN to give LOCK/UNLOCK real memory traffic;
// without it they are echoed like an unrecognised op and the lock logic is absent.
module falafel_lsu
  import falafel_pkg::*;
#(
  parameter logic [DATA_W-1:0] LOCK_ADDR    = LOCK_ADDR_DEFAULT,
  parameter logic [DATA_W-1:0] LOCK_SET_VAL = LOCK_SET_VAL_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  header_req_t       req_i,
  output logic              req_rdy_o,
  output header_rsp_t       rsp_o,
  input  logic              rsp_rdy_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  // RD_* issue a read and leave on grant; WT_* wait for its data. Only WT_*
  // states look at mem_rvalid_i, so stray or post-reset read data is dropped.
  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] RD_SIZE   = 4'd1;
  localparam logic [3:0] WT_SIZE   = 4'd2;
  localparam logic [3:0] RD_NEXT   = 4'd3;
  localparam logic [3:0] WT_NEXT   = 4'd4;
  localparam logic [3:0] WR_SIZE   = 4'd5;
  localparam logic [3:0] WR_NEXT   = 4'd6;
  localparam logic [3:0] RSP       = 4'd7;
`ifdef FALAFEL_LSU_LOCK_EN
  localparam logic [3:0] LOCK_RD   = 4'd8;
  localparam logic [3:0] LOCK_WT   = 4'd9;
  localparam logic [3:0] LOCK_WR   = 4'd10;
  localparam logic [3:0] UNLOCK_WR = 4'd11;
`else
  // Parameters kept for a uniform instantiation interface; unused in this build.
  logic unused_lock_cfg;
  assign unused_lock_cfg = ^{LOCK_ADDR, LOCK_SET_VAL};
`endif

  logic [3:0]        state_q;
  header_t           hdr_q;
  header_rsp_t       rsp_q;
  logic              live_q;
  logic [DATA_W-1:0] next_ptr;

  // Wraps modulo 2^DATA_W by construction.
  assign next_ptr = hdr_q.addr + BLOCK_NEXT_ADDR_OFFSET;

  // live_q keeps req_rdy_o low while reset is applied; IDLE alone cannot.
  assign req_rdy_o = live_q && (state_q == IDLE);
  assign rsp_o     = rsp_q;

  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would make ordering of statements matter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the header register is reset too, so mem_addr_o/mem_wdata_o are
      // defined from reset and an abandoned request leaves nothing behind.
      state_q <= IDLE;
      hdr_q   <= '0;
      rsp_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (req_i.val && req_rdy_o) begin
            hdr_q <= req_i.header;
            case (req_i.lsu_op)
              LOAD:                    state_q <= RD_SIZE;
              EDIT_SIZE_AND_NEXT_ADDR: state_q <= WR_SIZE;
              EDIT_NEXT_ADDR:          state_q <= WR_NEXT;
`ifdef FALAFEL_LSU_LOCK_EN
              LOCK:                    state_q <= LOCK_RD;
              UNLOCK:                  state_q <= UNLOCK_WR;
`endif
              default: begin
                rsp_q   <= '{val: 1'b1, header: req_i.header};
                state_q <= RSP;
              end
            endcase
          end
        end
        RD_SIZE: if (mem_gnt_i) state_q <= WT_SIZE;
        WT_SIZE: begin
          if (mem_rvalid_i) begin
            hdr_q.size <= mem_rdata_i;
            state_q    <= RD_NEXT;
          end
        end
        RD_NEXT: if (mem_gnt_i) state_q <= WT_NEXT;
        WT_NEXT: begin
          if (mem_rvalid_i) begin
            rsp_q <= '{val: 1'b1,
                       header: '{addr: hdr_q.addr, size: hdr_q.size, next_addr: mem_rdata_i}};
            state_q <= RSP;
          end
        end
        WR_SIZE: if (mem_gnt_i) state_q <= WR_NEXT;
        WR_NEXT: begin
          if (mem_gnt_i) begin
            rsp_q   <= '{val: 1'b1, header: hdr_q};
            state_q <= RSP;
          end
        end
`ifdef FALAFEL_LSU_LOCK_EN
        LOCK_RD: if (mem_gnt_i) state_q <= LOCK_WT;
        LOCK_WT: begin
          // Spin: a held lock sends us back to re-read it.
          if (mem_rvalid_i) state_q <= (mem_rdata_i == EMPTY_KEY) ? LOCK_WR : LOCK_RD;
        end
        LOCK_WR, UNLOCK_WR: begin
          if (mem_gnt_i) begin
            rsp_q   <= '{val: 1'b1, header: hdr_q};
            state_q <= RSP;
          end
        end
`endif
        RSP: begin
          if (rsp_rdy_i) begin
            rsp_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory port is a pure decode of registered state, so it cannot change
  // while a request waits for its grant.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      RD_SIZE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = hdr_q.addr;
      end
      RD_NEXT: begin
        mem_req_o  = 1'b1;
        mem_addr_o = next_ptr;
      end
      WR_SIZE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = hdr_q.addr;
        mem_wdata_o = hdr_q.size;
      end
      WR_NEXT: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = next_ptr;
        mem_wdata_o = hdr_q.next_addr;
      end
`ifdef FALAFEL_LSU_LOCK_EN
      LOCK_RD: begin
        mem_req_o  = 1'b1;
        mem_addr_o = LOCK_ADDR;
      end
      LOCK_WR: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = LOCK_ADDR;
        mem_wdata_o = LOCK_SET_VAL;
      end
      UNLOCK_WR: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = LOCK_ADDR;
        mem_wdata_o = EMPTY_KEY;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_falafel_lsu.sv
// tb_falafel_lsu: self-checking bench for falafel_lsu. A behavioural memory with
// programmable grant / read-data delays serves the DUT; a transaction-level model
// predicts each response header, the ordered list of memory accesses and the
// response latency. Honours FALAFEL_LSU_LOCK_EN the same way as the design.
`timescale 1ns/1ps
module tb_falafel_lsu;
  import falafel_pkg::*;

  localparam logic [DATA_W-1:0] TB_LOCK_ADDR = 64'h0000_0000_0000_1000;
  localparam logic [DATA_W-1:0] TB_LOCK_SET  = 64'h1;
  localparam logic [DATA_W-1:0] TOP_ADDR     = 64'hFFFF_FFFF_FFFF_FFF8;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  falafel_lsu_if bus ();

  falafel_lsu #(
    .LOCK_ADDR    (TB_LOCK_ADDR),
    .LOCK_SET_VAL (TB_LOCK_SET)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (bus.req),
    .req_rdy_o    (bus.req_rdy),
    .rsp_o        (bus.rsp),
    .rsp_rdy_i    (bus.rsp_rdy),
    .mem_req_o    (bus.mem_req),
    .mem_we_o     (bus.mem_we),
    .mem_addr_o   (bus.mem_addr),
    .mem_wdata_o  (bus.mem_wdata),
    .mem_gnt_i    (bus.mem_gnt),
    .mem_rvalid_i (bus.mem_rvalid),
    .mem_rdata_i  (bus.mem_rdata)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [DATA_W-1:0] mem [logic [DATA_W-1:0]];
  acc_t              log_q [$];
  int                gnt_delay    = 0;
  int                rvalid_delay = 0;
  int                lock_busy    = 0;   // lock reads still to report as held
  bit                spurious_en  = 1'b0;

  function automatic logic [DATA_W-1:0] mem_rd(input logic [DATA_W-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  initial begin : responder
    int                wait_cnt = 0;
    bit                rd_pend  = 1'b0;
    int                rd_wait  = 0;
    logic [DATA_W-1:0] rd_data  = '0;
    acc_t              snap     = '0;
    bit                snap_ok  = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk_i);
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = {$urandom, $urandom};
      if (rd_pend) begin
        if (rd_wait == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = rd_data;
          rd_pend        = 1'b0;
        end else begin
          rd_wait--;
        end
      end else if (spurious_en && $urandom_range(3) == 0) begin
        bus.mem_rvalid = 1'b1;
      end
      // A request still waiting for grant must present identical outputs.
      if (snap_ok && bus.mem_req)
        check("mem_hold", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, snap);
      snap_ok     = 1'b0;
      bus.mem_gnt = 1'b0;
      if (bus.mem_req) begin
        if (wait_cnt >= gnt_delay) begin
          bus.mem_gnt = 1'b1;
          wait_cnt    = 0;
          log_q.push_back('{we: bus.mem_we, addr: bus.mem_addr,
                            wdata: bus.mem_we ? bus.mem_wdata : '0});
          if (bus.mem_we) begin
            mem[bus.mem_addr] = bus.mem_wdata;
          end else begin
            rd_pend = 1'b1;
            rd_wait = rvalid_delay;
            if (bus.mem_addr == TB_LOCK_ADDR && lock_busy > 0) begin
              rd_data = 64'h1;
              lock_busy--;
            end else begin
              rd_data = mem_rd(bus.mem_addr);
            end
          end
        end else begin
          wait_cnt++;
          snap    = '{we: bus.mem_we, addr: bus.mem_addr, wdata: bus.mem_wdata};
          snap_ok = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- transaction driver + reference model ----------------
  task automatic run_txn(input string name, input req_lsu_op_e op, input header_t h,
                         input int hold);
    acc_t        exp_q [$];
    header_t     exp_h;
    int          exp_lat;
    int          lat;
    int          n;
    bit          seen;
    int unsigned acc_cyc;
    header_rsp_t held;

    // Expected behaviour straight from the operation rules.
    exp_h = h;
    if (op == LOAD) begin
      exp_q.push_back('{we: 1'b0, addr: h.addr, wdata: '0});
      exp_q.push_back('{we: 1'b0, addr: h.addr + BLOCK_NEXT_ADDR_OFFSET, wdata: '0});
      exp_h.size      = mem_rd(h.addr);
      exp_h.next_addr = mem_rd(h.addr + BLOCK_NEXT_ADDR_OFFSET);
    end else if (op == EDIT_SIZE_AND_NEXT_ADDR) begin
      exp_q.push_back('{we: 1'b1, addr: h.addr, wdata: h.size});
      exp_q.push_back('{we: 1'b1, addr: h.addr + BLOCK_NEXT_ADDR_OFFSET, wdata: h.next_addr});
    end else if (op == EDIT_NEXT_ADDR) begin
      exp_q.push_back('{we: 1'b1, addr: h.addr + BLOCK_NEXT_ADDR_OFFSET, wdata: h.next_addr});
`ifdef FALAFEL_LSU_LOCK_EN
    end else if (op == LOCK) begin
      for (int i = 0; i <= lock_busy; i++)
        exp_q.push_back('{we: 1'b0, addr: TB_LOCK_ADDR, wdata: '0});
      exp_q.push_back('{we: 1'b1, addr: TB_LOCK_ADDR, wdata: TB_LOCK_SET});
    end else if (op == UNLOCK) begin
      exp_q.push_back('{we: 1'b1, addr: TB_LOCK_ADDR, wdata: EMPTY_KEY});
`endif
    end
    // Response is sampled one edge after the last access completes; each access
    // costs one edge plus grant wait, a read one more edge plus data wait.
    exp_lat = 1;
    foreach (exp_q[i])
      exp_lat += 1 + gnt_delay + (exp_q[i].we ? 0 : 1 + rvalid_delay);

    log_q.delete();
    n = 0;
    while (!bus.req_rdy && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!bus.req_rdy) begin
      check({name, "/rdy_timeout"}, 0, 1);
      lock_busy = 0;
      return;
    end
    bus.req = '{val: 1'b1, lsu_op: op, header: h};
    acc_cyc = cyc + 1;
    @(negedge clk_i);
    bus.req = '{val: 1'b0, lsu_op: req_lsu_op_e'(3'($urandom_range(7))),
                header: {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}};

    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (bus.rsp.val) seen = 1'b1;
      else @(negedge clk_i);
    end
    if (!seen) begin
      check({name, "/rsp_timeout"}, 0, 1);
      lock_busy = 0;
      return;
    end
    lat = int'(cyc - acc_cyc) + 1;
    check({name, "/latency"}, lat, exp_lat);
    check({name, "/rsp"}, bus.rsp, {1'b1, exp_h});
    check({name, "/n_access"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s/access%0d", name, i), log_q[i], exp_q[i]);

    held = bus.rsp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check({name, "/rsp_stall"}, {bus.rsp, bus.req_rdy}, {held, 1'b0});
    end
    bus.rsp_rdy = 1'b1;
    check({name, "/rdy_in_handshake"}, bus.req_rdy, 1'b0);
    @(negedge clk_i);
    bus.rsp_rdy = 1'b0;
    check({name, "/rsp_cleared"}, bus.rsp.val, 1'b0);
    lock_busy = 0;
  endtask

  initial begin : watchdog
    #200_000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin : main
    header_t h;
    int      hold;
    bus.req     = '0;
    bus.rsp_rdy = 1'b0;

    repeat (3) @(negedge clk_i);
    check("reset/req_rdy", bus.req_rdy, 1'b0);
    check("reset/rsp", bus.rsp, '0);
    check("reset/mem", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, '0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("reset/req_rdy_after", bus.req_rdy, 1'b1);

    // Zero-wait LOAD: two reads, response sampled 5 edges after acceptance.
    mem[64'h100] = 64'h40;
    mem[64'h108] = 64'h200;
    run_txn("load_0x100", LOAD, '{addr: 64'h100, size: 64'h0, next_addr: 64'h0}, 0);

    // Zero-wait edit: response 3 edges after acceptance.
    run_txn("edit_sn_zw", EDIT_SIZE_AND_NEXT_ADDR,
            '{addr: 64'h280, size: 64'h18, next_addr: 64'h300}, 0);

    // Grant held off 3 cycles; memory outputs must not move meanwhile.
    gnt_delay = 3;
    run_txn("edit_sn_gnt3", EDIT_SIZE_AND_NEXT_ADDR,
            '{addr: 64'h200, size: 64'h30, next_addr: 64'h0}, 0);
    check("edit_sn_gnt3/mem200", mem_rd(64'h200), 64'h30);
    gnt_delay = 0;

    // Lock held for 4 reads, then free.
    mem[TB_LOCK_ADDR] = EMPTY_KEY;
    lock_busy = 4;
    run_txn("lock_spin", LOCK, '{addr: 64'h0, size: 64'h0, next_addr: 64'h0}, 1);
`ifdef FALAFEL_LSU_LOCK_EN
    check("lock_spin/lock_word", mem_rd(TB_LOCK_ADDR), TB_LOCK_SET);
`endif
    run_txn("unlock", UNLOCK, '{addr: 64'h0, size: 64'h0, next_addr: 64'h0}, 0);
    check("unlock/lock_word", mem_rd(TB_LOCK_ADDR), EMPTY_KEY);

    // next_addr slot of the topmost block wraps to address 0.
    run_txn("edit_next_wrap", EDIT_NEXT_ADDR,
            '{addr: TOP_ADDR, size: 64'h0, next_addr: 64'hABCD_0000}, 0);
    check("edit_next_wrap/mem0", mem_rd(64'h0), 64'hABCD_0000);

    // Back-pressured response for 10 cycles.
    run_txn("rsp_stall10", LOAD, '{addr: 64'h100, size: 64'h0, next_addr: 64'h0}, 10);

    // Unrecognised op code: echo only.
    run_txn("bad_op", req_lsu_op_e'(3'd6), '{addr: 64'h5, size: 64'h6, next_addr: 64'h7}, 0);

    // Reset while waiting for LOAD's first read; the data arrives afterwards.
    mem[64'h300] = 64'h11;
    mem[64'h308] = 64'h22;
    rvalid_delay = 3;
    log_q.delete();
    bus.req = '{val: 1'b1, lsu_op: LOAD, header: '{addr: 64'h300, size: 64'h0, next_addr: 64'h0}};
    @(negedge clk_i);
    bus.req = '0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("mid_reset/req_rdy", bus.req_rdy, 1'b0);
    check("mid_reset/rsp", bus.rsp, '0);
    check("mid_reset/mem", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      check("post_reset/idle", {bus.rsp.val, bus.mem_req, bus.req_rdy}, 3'b001);
    end
    check("post_reset/n_access", log_q.size(), 1);
    rvalid_delay = 0;
    run_txn("load_after_reset", LOAD, '{addr: 64'h300, size: 64'h0, next_addr: 64'h0}, 0);

    // Randomised mix with variable memory timing and stray read-data pulses.
    spurious_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      gnt_delay    = $urandom_range(2);
      rvalid_delay = $urandom_range(2);
      hold         = $urandom_range(3);
      h.addr       = ($urandom_range(9) == 0) ? TOP_ADDR : {55'd0, 6'($urandom_range(63)), 3'b000};
      h.size       = {$urandom, $urandom};
      h.next_addr  = {$urandom, $urandom};
      if ($urandom_range(1) == 0) mem[h.addr] = {$urandom, $urandom};
      begin
        req_lsu_op_e op;
        op = req_lsu_op_e'(3'($urandom_range(7)));
        if (op == LOCK) begin
          mem[TB_LOCK_ADDR] = EMPTY_KEY;
          lock_busy = $urandom_range(3);
        end
        run_txn($sformatf("rand%0d", t), op, h, hold);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/falafel_lsu.md
FALAFEL_LSU -- requirements
Module: falafel_lsu

Interface
REQ-001 SHALL have parameter LOCK_ADDR, default 64'h0, byte address of the allocator lock word.
REQ-002 SHALL have parameter LOCK_SET_VAL, default 64'h1, value written to claim the lock.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  header_req_t  allocator request; valid is req_i.val.
REQ-006 SHALL have port req_rdy_o  output  1  request accepted when req_i.val && req_rdy_o.
REQ-007 SHALL have port rsp_o  output  header_rsp_t  response; valid is rsp_o.val.
REQ-008 SHALL have port rsp_rdy_i  input  1  response consumed when rsp_o.val && rsp_rdy_i.
REQ-009 SHALL have ports mem_req_o (output, 1), mem_we_o (output, 1), mem_addr_o (output, DATA_W), mem_wdata_o (output, DATA_W); word memory request.
REQ-010 SHALL have ports mem_gnt_i (input, 1), mem_rvalid_i (input, 1), mem_rdata_i (input, DATA_W); grant, read-data valid, read data.

Function
REQ-011 SHALL be the responder for header_req_t: each accepted request yields exactly one rsp_o beat.
REQ-012 SHALL assert req_rdy_o only in IDLE with no response pending; request fields are registered on acceptance.
REQ-013 SHALL hold mem_req_o and all mem_* outputs stable until mem_gnt_i; at most one memory access outstanding.
REQ-014 SHALL complete a write on grant; a read on the first mem_rvalid_i after its grant.
REQ-015 LOAD: read header.addr -> size, then header.addr+BLOCK_NEXT_ADDR_OFFSET -> next_addr; rsp header = {addr echoed, size, next_addr}.
REQ-016 EDIT_SIZE_AND_NEXT_ADDR: write size to addr, then next_addr to addr+8; rsp echoes request header.
REQ-017 EDIT_NEXT_ADDR: single write of next_addr to addr+8; rsp echoes request header.
REQ-018 LOCK: read LOCK_ADDR; if EMPTY_KEY, write LOCK_SET_VAL and respond; otherwise re-read (spin) until EMPTY_KEY.
REQ-019 UNLOCK: write EMPTY_KEY to LOCK_ADDR; respond.
REQ-020 Unrecognised lsu_op: no memory access; respond next cycle echoing header.
REQ-021 Address offset arithmetic SHALL be DATA_W-bit modulo 2^DATA_W (addr 64'hFFFF_FFFF_FFFF_FFF8 + 8 wraps to 0).
REQ-022 FSM states: IDLE, LOCK_RD, LOCK_WT, LOCK_WR, RD_SIZE, WT_SIZE, RD_NEXT, WT_NEXT, WR_SIZE, WR_NEXT, UNLOCK_WR, RSP.
REQ-023 rsp_o SHALL be registered, held constant in RSP until rsp_rdy_i, then return to IDLE; no new request accepted in the handshake cycle.
REQ-024 Zero-wait memory (gnt same cycle, rvalid next cycle): LOAD accepted at cycle T SHALL give rsp_o.val at T+5; EDIT_SIZE_AND_NEXT_ADDR at T+3.
REQ-025 mem_rvalid_i outside a WT_* state SHALL be ignored.

Reset
REQ-026 On rst_ni low: FSM to IDLE; req_rdy_o=0 during reset, 1 in first cycle after; rsp_o='0; mem_req_o=0, mem_we_o=0, mem_addr_o='0, mem_wdata_o='0.
REQ-027 Reset mid-operation SHALL abandon the request without response; a read returning after reset SHALL be ignored per REQ-025.

Configuration
REQ-028 Macro FALAFEL_LSU_LOCK_EN defined: LOCK/UNLOCK perform memory traffic per REQ-018/019.
REQ-029 Macro FALAFEL_LSU_LOCK_EN undefined: LOCK/UNLOCK issue no memory access and respond next cycle like REQ-020; lock states and LOCK_SET_VAL logic not synthesised.

Structure
REQ-030 header_t, header_req_t, header_rsp_t, req_lsu_op_e, DATA_W, BLOCK_NEXT_ADDR_OFFSET, EMPTY_KEY SHALL come from falafel_pkg; no local redefinition.
REQ-031 Any new shared constant (e.g. default lock value) SHALL be added to falafel_pkg.
REQ-032 Single module, no sub-modules; memory port sequencing inline in the FSM.

Verification
REQ-033 LOAD addr=0x100, mem[0x100]=0x40, mem[0x108]=0x200, zero-wait -> rsp {0x100,0x40,0x200} at T+5, two reads seen.
REQ-034 EDIT_SIZE_AND_NEXT_ADDR addr=0x200,size=0x30,next=0x0, gnt delayed 3 cycles -> writes 0x30@0x200 then 0x0@0x208, outputs stable while waiting.
REQ-035 LOCK with mem[LOCK_ADDR]=1 for 4 reads then 0 -> 5 reads, one write of 0x1, single response; UNLOCK -> write 0 to LOCK_ADDR.
REQ-036 EDIT_NEXT_ADDR addr=0xFFFF_FFFF_FFFF_FFF8 -> write to address 0x0.
REQ-037 rsp_rdy_i low 10 cycles -> rsp_o stable, req_rdy_o low throughout.
REQ-038 rst_ni pulsed during WT_SIZE, rvalid arrives after -> no response, outputs at reset values, next LOAD correct.
